serial_subtractor: RTL and testbench

Bit-serial WIDTH-bit unsigned subtractor computing D = A − B − Bin one bit per clock through a single full-subtractor cell and a registered borrow. It is the inverse counterpart of the team's 4-bit ripple-carry adder and shares the same operand width and bit ordering. Area is traded for latency: one cell replaces WIDTH cells. Operands enter and results leave through valid/ready handshakes, so the block sits between an operand source and a result consumer in the arithmetic datapath.

---
 rtl/serial_sub_pkg.sv | 26 ++
 rtl/full_subtractor.sv | 20 ++
 rtl/serial_subtractor.sv | 127 ++++++++++++
 tb/tb_serial_subtractor.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
`default_nettype none
//============================================================================
// Module      : serial_sub_pkg
// Description : Shared definitions for the bit-serial subtractor: FSM state
//               encoding, default operand width and counter-width helper.
// Revision    : 1.0 - initial release
//============================================================================
package serial_sub_pkg;

    // Default operand width, matching the 4-bit ripple-carry adder.
    localparam int DEFAULT_WIDTH = 4;

    // Three-state sequencer encoding, explicit 2-bit width.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Bit-counter width; never less than one bit.
    function automatic int cnt_width(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/full_subtractor.sv
`default_nettype none
//============================================================================
// Module      : full_subtractor
// Description : Single-bit combinational full subtractor cell,
//               diff = x - y - bi, bo = borrow out.
// Revision    : 1.0 - initial release
//============================================================================
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic diff,
    output logic bo
);

    assign diff = x ^ y ^ bi;
    assign bo   = (~x & y) | (~(x ^ y) & bi);

endmodule
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
//============================================================================
// Module      : serial_subtractor
// Description : Bit-serial WIDTH-bit unsigned subtractor, D = A - B - Bin,
//               one bit per clock, LSB first, through a single full
//               subtractor cell and a registered borrow. Operands and
//               results use valid/ready handshakes.
//               Optional macro OVF_FLAG_EN adds the signed overflow port ovf.
// Revision    : 1.0 - initial release
//============================================================================
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
`ifdef OVF_FLAG_EN
    output logic             ovf,
`endif
    output logic             bout
);

    localparam int                 c_cnt_w = cnt_width(WIDTH);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WIDTH - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_d;
    logic               r_borrow;
    logic [c_cnt_w-1:0] r_cnt;
    logic               w_accept;
    logic               w_step;
    logic               w_last;
    logic               w_diff;
    logic               w_bo;

    assign w_accept = (r_state == S_IDLE) && in_valid;
    assign w_step   = (r_state == S_RUN);
    assign w_last   = w_step && (r_cnt == c_last);

    // Handshake flags decode straight from the state register.
    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign d         = r_d;
    assign bout      = r_borrow;

    full_subtractor u_fs (
        .x    (r_a[0]),
        .y    (r_b[0]),
        .bi   (r_borrow),
        .diff (w_diff),
        .bo   (w_bo)
    );

    // State register; reset abandons any in-flight operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode: accept in IDLE, WIDTH serial steps, hold until taken.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (in_valid)  w_state_nxt = S_RUN;
            S_RUN:   if (w_last)    w_state_nxt = S_DONE;
            S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
            default:                w_state_nxt = S_IDLE;
        endcase
    end

    // Serial datapath: load on accept, then one bit per cycle LSB first.
    // The counter stops at WIDTH-1 so it only wraps on the next accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_d      <= '0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
        end else if (w_accept) begin
            r_a      <= a;
            r_b      <= b;
            r_borrow <= bin;
            r_cnt    <= '0;
        end else if (w_step) begin
            r_a      <= r_a >> 1;
            r_b      <= r_b >> 1;
            r_d      <= {w_diff, r_d[WIDTH-1:1]};
            r_borrow <= w_bo;
            if (!w_last) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

`ifdef OVF_FLAG_EN
    logic r_ovf;

    // Signed overflow: borrow into the MSB step XOR borrow out of it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_last) begin
            r_ovf <= r_borrow ^ w_bo;
        end
    end

    assign ovf = r_ovf;
`endif

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
//============================================================================
// Module      : tb_serial_subtractor
// Description : Self-checking bench for serial_subtractor (WIDTH = 4):
//               directed vectors, backpressure, mid-run reset and a
//               randomised sweep against an arithmetic model.
//               Honours OVF_FLAG_EN when defined.
// Revision    : 1.0 - initial release
//============================================================================
module tb_serial_subtractor;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] d;
    logic             bout;
`ifdef OVF_FLAG_EN
    logic             ovf;
`endif

    int checks;
    int failures;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d         (d),
`ifdef OVF_FLAG_EN
        .ovf       (ovf),
`endif
        .bout      (bout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction: accept, wait for result, optional backpressure
    // with a rejected second request, then the output handshake.
    task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_op,
                          input logic tbin, input logic [WIDTH-1:0] exp_d,
                          input logic exp_bout, input logic exp_ovf,
                          input int hold, input bit rand_rdy);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        check_eq("in_ready_idle", in_ready, 1);
        a = ta; b = tb_op; bin = tbin; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        a = '0; b = '0; bin = 1'b0;
        check_eq("in_ready_busy", in_ready, 0);
        n = 0;
        while (!out_valid && n < 20) begin
            if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        out_ready = 1'b0;
        check_eq("latency", n, WIDTH);
        check_eq("d", d, exp_d);
        check_eq("bout", bout, exp_bout);
`ifdef OVF_FLAG_EN
        check_eq("ovf", ovf, exp_ovf);
`endif
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            a = ~ta; b = ~tb_op; bin = ~tbin;
            tick();
            check_eq("hold_valid", out_valid, 1);
            check_eq("hold_in_ready", in_ready, 0);
            check_eq("hold_d", d, exp_d);
            check_eq("hold_bout", bout, exp_bout);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_eq("post_hs_in_ready", in_ready, 1);
        check_eq("post_hs_out_valid", out_valid, 0);
    endtask

    // Watchdog so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WIDTH-1:0] ra, rb, ed;
        logic             rbin, eb, eo;
        logic [WIDTH:0]   full;
        int               s;

        checks = 0; failures = 0;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; bin = 1'b0;
        repeat (3) tick();
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_d", d, 0);
        check_eq("rst_bout", bout, 0);
`ifdef OVF_FLAG_EN
        check_eq("rst_ovf", ovf, 0);
`endif
        rst = 1'b0;
        tick();
        check_eq("rst_in_ready", in_ready, 1);

        // Directed vectors: a, b, bin, d, bout, ovf.
        run_op(4'd9,  4'd3,  1'b0, 4'd6,  1'b0, 1'b1, 0, 1'b0);
        run_op(4'd3,  4'd9,  1'b0, 4'd10, 1'b1, 1'b1, 0, 1'b0);
        run_op(4'd0,  4'd0,  1'b1, 4'hF,  1'b1, 1'b0, 0, 1'b0);
        run_op(4'd7,  4'hF,  1'b0, 4'h8,  1'b1, 1'b1, 0, 1'b0);
        run_op(4'd5,  4'd2,  1'b0, 4'd3,  1'b0, 1'b0, 0, 1'b0);

        // Backpressure for 5 cycles with a second request pending.
        run_op(4'd10, 4'd1,  1'b1, 4'd8,  1'b0, 1'b0, 5, 1'b0);
        // Next op accepted right after the handshake.
        run_op(4'd15, 4'd14, 1'b0, 4'd1,  1'b0, 1'b0, 0, 1'b0);

        // Reset during RUN at bit index 2.
        a = 4'd13; b = 4'd6; bin = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        check_eq("midrst_out_valid", out_valid, 0);
        check_eq("midrst_d", d, 0);
        check_eq("midrst_bout", bout, 0);
`ifdef OVF_FLAG_EN
        check_eq("midrst_ovf", ovf, 0);
`endif
        tick();
        rst = 1'b0;
        tick();
        check_eq("midrst_in_ready", in_ready, 1);
        run_op(4'd12, 4'd4, 1'b0, 4'd8, 1'b0, 1'b0, 0, 1'b0);

        // Randomised sweep against an arithmetic model.
        for (int k = 0; k < 200; k++) begin
            ra   = WIDTH'($urandom_range(0, 15));
            rb   = WIDTH'($urandom_range(0, 15));
            rbin = 1'($urandom_range(0, 1));
            full = {1'b0, ra} - {1'b0, rb} - {{WIDTH{1'b0}}, rbin};
            ed   = full[WIDTH-1:0];
            eb   = full[WIDTH];
            s    = int'($signed(ra)) - int'($signed(rb)) - int'(rbin);
            eo   = (s > 7) || (s < -8);
            run_op(ra, rb, rbin, ed, eb, eo, $urandom_range(0, 2), 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
